// File: rtl/gray_binary_decoder.sv
// gray_binary_decoder
// Synchronizes a Gray-coded input, decodes it to binary and checks that
// successive samples differ in exactly one bit. Reports step direction,
// illegal jumps and a saturating error count.
// Optional net position counter: define GRAY_DEC_POS_CNT_EN to build it,
// otherwise pos_cnt is tied to zero.
module gray_binary_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] g,
    input  logic             clr_err,
    output logic [WIDTH-1:0] b,
    output logic             b_valid,
    output logic             dir,
    output logic             step_err,
    output logic [7:0]       err_cnt,
    output logic [15:0]      pos_cnt
);

    typedef enum logic {
        ST_FIRST,
        ST_TRACK
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [SYNC_STAGES-1:0]            fill_q;
    logic [WIDTH-1:0]                  s, d, p_q, p_d, b_d, diff, b_inc;
    logic                              b_valid_d, dir_d, step_err_d, one_bit;

    // Synchronizer chain; fill_q tracks which stages hold a post-reset sample
    // so the first-sample load takes a real g value, not the flushed zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            fill_q <= '0;
        end else begin
            sync_q[0] <= g;
            fill_q[0] <= 1'b1;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
                fill_q[i] <= fill_q[i-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Gray-to-binary decode: each bit is the XOR of all Gray bits at or above it.
    always_comb begin
        logic acc;
        d   = '0;
        acc = 1'b0;
        for (int unsigned i = 1; i <= WIDTH; i++) begin
            acc        = acc ^ s[WIDTH-i];
            d[WIDTH-i] = acc;
        end
    end

    assign diff    = s ^ p_q;
    assign one_bit = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
    assign b_inc   = b + WIDTH'(1);

    // Next-state: first-sample load, hold, legal step or illegal-jump resync.
    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        b_d        = b;
        b_valid_d  = 1'b0;
        dir_d      = dir;
        step_err_d = 1'b0;
        case (state_q)
            ST_FIRST: begin
                if (fill_q[SYNC_STAGES-1]) begin
                    p_d       = s;
                    b_d       = d;
                    b_valid_d = 1'b1;
                    state_d   = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (s != p_q) begin
                    p_d = s;
                    b_d = d;
                    if (one_bit) begin
                        b_valid_d = 1'b1;
                        dir_d     = (d == b_inc);
                    end else begin
                        step_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_FIRST;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_FIRST;
            p_q      <= '0;
            b        <= '0;
            b_valid  <= 1'b0;
            dir      <= 1'b0;
            step_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            b        <= b_d;
            b_valid  <= b_valid_d;
            dir      <= dir_d;
            step_err <= step_err_d;
        end
    end

    // Saturating error counter; a clear coinciding with an error leaves 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= {7'b0, step_err_d};
        end else if (step_err_d && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

`ifdef GRAY_DEC_POS_CNT_EN
    // Net position: counts legal steps only, wraps modulo 2^16.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_cnt <= '0;
        end else if (b_valid_d && (state_q == ST_TRACK)) begin
            pos_cnt <= dir_d ? pos_cnt + 16'd1 : pos_cnt - 16'd1;
        end
    end
`else
    assign pos_cnt = '0;
`endif

endmodule

// File: tb/tb_gray_binary_decoder.sv
// Directed self-checking bench for gray_binary_decoder (WIDTH=4, SYNC_STAGES=2).
module tb_gray_binary_decoder;

`ifdef GRAY_DEC_POS_CNT_EN
    localparam bit POS_EN = 1'b1;
`else
    localparam bit POS_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  g;
    logic        clr_err;
    logic [3:0]  b;
    logic        b_valid;
    logic        dir;
    logic        step_err;
    logic [7:0]  err_cnt;
    logic [15:0] pos_cnt;

    int tests_run = 0;
    int fails     = 0;

    gray_binary_decoder #(.WIDTH(4), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .g        (g),
        .clr_err  (clr_err),
        .b        (b),
        .b_valid  (b_valid),
        .dir      (dir),
        .step_err (step_err),
        .err_cnt  (err_cnt),
        .pos_cnt  (pos_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe n rising edges (sampled 1 time unit after each) and record pulses.
    task automatic watch(input int n, output int nvalid, output int valid_at,
                         output int nerr, output int err_at, output bit both);
        nvalid = 0; valid_at = 0; nerr = 0; err_at = 0; both = 1'b0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            if (b_valid === 1'b1) begin nvalid++; valid_at = i; end
            if (step_err === 1'b1) begin nerr++; err_at = i; end
            if (b_valid === 1'b1 && step_err === 1'b1) both = 1'b1;
        end
    endtask

    // Assert reset with g set, release between edges.
    task automatic do_reset(input logic [3:0] gv);
        @(negedge clk);
        rst = 1'b1;
        g   = gv;
        #2 rst = 1'b0;
    endtask

    task automatic test_reset();
        int nv, va, ne, ea; bit both;
        rst = 1'b1; g = 4'b0110; clr_err = 1'b0;
        @(posedge clk); #2;
        tests_run++; if (b !== 4'd0) begin fails++; $display("FAIL reset_b: got %b want 0000", b); end
        tests_run++; if (b_valid !== 1'b0) begin fails++; $display("FAIL reset_b_valid: got %b want 0", b_valid); end
        tests_run++; if (dir !== 1'b0) begin fails++; $display("FAIL reset_dir: got %b want 0", dir); end
        tests_run++; if (step_err !== 1'b0) begin fails++; $display("FAIL reset_step_err: got %b want 0", step_err); end
        tests_run++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        tests_run++; if (pos_cnt !== 16'd0) begin fails++; $display("FAIL reset_pos_cnt: got %0d want 0", pos_cnt); end
        @(negedge clk); #2 rst = 1'b0;
        watch(8, nv, va, ne, ea, both);
        tests_run++; if (nv !== 1) begin fails++; $display("FAIL first_valid_count: got %0d want 1", nv); end
        tests_run++; if (va !== 3) begin fails++; $display("FAIL first_valid_edge: got %0d want 3", va); end
        tests_run++; if (b !== 4'b0100) begin fails++; $display("FAIL first_b: got %b want 0100", b); end
        tests_run++; if (ne !== 0) begin fails++; $display("FAIL first_step_err: got %0d want 0", ne); end
    endtask

    task automatic test_up_walk();
        int nv, va, ne, ea; bit both;
        logic [3:0]  gseq [3] = '{4'b0001, 4'b0011, 4'b0010};
        logic [3:0]  bexp [3] = '{4'd1, 4'd2, 4'd3};
        logic [15:0] pexp [3] = '{16'd1, 16'd2, 16'd3};
        do_reset(4'b0000);
        watch(5, nv, va, ne, ea, both);
        tests_run++; if (b !== 4'd0) begin fails++; $display("FAIL walk_b0: got %0d want 0", b); end
        for (int k = 0; k < 3; k++) begin
            g = gseq[k];
            watch(5, nv, va, ne, ea, both);
            tests_run++; if (nv !== 1) begin fails++; $display("FAIL walk_valid_count[%0d]: got %0d want 1", k, nv); end
            tests_run++; if (va !== 3) begin fails++; $display("FAIL walk_valid_edge[%0d]: got %0d want 3", k, va); end
            tests_run++; if (b !== bexp[k]) begin fails++; $display("FAIL walk_b[%0d]: got %0d want %0d", k, b, bexp[k]); end
            tests_run++; if (dir !== 1'b1) begin fails++; $display("FAIL walk_dir[%0d]: got %b want 1", k, dir); end
            tests_run++; if (ne !== 0) begin fails++; $display("FAIL walk_step_err[%0d]: got %0d want 0", k, ne); end
            tests_run++; if (pos_cnt !== (POS_EN ? pexp[k] : 16'd0)) begin fails++; $display("FAIL walk_pos[%0d]: got %0d want %0d", k, pos_cnt, POS_EN ? pexp[k] : 16'd0); end
        end
    endtask

    task automatic test_mid_reset();
        int nv, va, ne, ea; bit both;
        // Currently g=0010, b=3, dir=1; reset between edges.
        #3 rst = 1'b1;
        #1;
        tests_run++; if (b !== 4'd0) begin fails++; $display("FAIL mid_reset_b: got %0d want 0", b); end
        tests_run++; if (dir !== 1'b0) begin fails++; $display("FAIL mid_reset_dir: got %b want 0", dir); end
        tests_run++; if (pos_cnt !== 16'd0) begin fails++; $display("FAIL mid_reset_pos: got %0d want 0", pos_cnt); end
        tests_run++; if (b_valid !== 1'b0 || step_err !== 1'b0) begin fails++; $display("FAIL mid_reset_pulses: got %b%b want 00", b_valid, step_err); end
        #2 rst = 1'b0;
        watch(5, nv, va, ne, ea, both);
        tests_run++; if (nv !== 1) begin fails++; $display("FAIL mid_first_valid: got %0d want 1", nv); end
        tests_run++; if (b !== 4'd3) begin fails++; $display("FAIL mid_first_b: got %0d want 3", b); end
        tests_run++; if (ne !== 0) begin fails++; $display("FAIL mid_first_step_err: got %0d want 0", ne); end
        tests_run++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL mid_err_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_wrap();
        int nv, va, ne, ea; bit both;
        do_reset(4'b0000);
        watch(5, nv, va, ne, ea, both);
        g = 4'b1000;
        watch(5, nv, va, ne, ea, both);
        tests_run++; if (b !== 4'd15) begin fails++; $display("FAIL wrap_down_b: got %0d want 15", b); end
        tests_run++; if (dir !== 1'b0) begin fails++; $display("FAIL wrap_down_dir: got %b want 0", dir); end
        tests_run++; if (nv !== 1 || ne !== 0) begin fails++; $display("FAIL wrap_down_pulses: got %0d/%0d want 1/0", nv, ne); end
        tests_run++; if (pos_cnt !== (POS_EN ? 16'hFFFF : 16'd0)) begin fails++; $display("FAIL wrap_down_pos: got %h want %h", pos_cnt, POS_EN ? 16'hFFFF : 16'd0); end
        g = 4'b0000;
        watch(5, nv, va, ne, ea, both);
        tests_run++; if (b !== 4'd0) begin fails++; $display("FAIL wrap_up_b: got %0d want 0", b); end
        tests_run++; if (dir !== 1'b1) begin fails++; $display("FAIL wrap_up_dir: got %b want 1", dir); end
        tests_run++; if (nv !== 1 || ne !== 0) begin fails++; $display("FAIL wrap_up_pulses: got %0d/%0d want 1/0", nv, ne); end
        tests_run++; if (pos_cnt !== 16'd0) begin fails++; $display("FAIL wrap_up_pos: got %h want 0000", pos_cnt); end
    endtask

    task automatic test_illegal_jump();
        int nv, va, ne, ea; bit both;
        g = 4'b0011;
        watch(5, nv, va, ne, ea, both);
        tests_run++; if (ne !== 1) begin fails++; $display("FAIL jump_err_count: got %0d want 1", ne); end
        tests_run++; if (ea !== 3) begin fails++; $display("FAIL jump_err_edge: got %0d want 3", ea); end
        tests_run++; if (nv !== 0) begin fails++; $display("FAIL jump_b_valid: got %0d want 0", nv); end
        tests_run++; if (both !== 1'b0) begin fails++; $display("FAIL jump_exclusive: got %b want 0", both); end
        tests_run++; if (b !== 4'd2) begin fails++; $display("FAIL jump_b: got %0d want 2", b); end
        tests_run++; if (err_cnt !== 8'd1) begin fails++; $display("FAIL jump_err_cnt: got %0d want 1", err_cnt); end
        tests_run++; if (dir !== 1'b1) begin fails++; $display("FAIL jump_dir: got %b want 1", dir); end
        tests_run++; if (pos_cnt !== 16'd0) begin fails++; $display("FAIL jump_pos: got %0d want 0", pos_cnt); end
    endtask

    task automatic test_saturation_clear();
        for (int i = 0; i < 260; i++) begin
            g = g ^ 4'b0011;
            repeat (2) @(posedge clk);
            #1;
        end
        repeat (4) @(posedge clk);
        #1;
        tests_run++; if (err_cnt !== 8'd255) begin fails++; $display("FAIL sat_err_cnt: got %0d want 255", err_cnt); end
        // g is 0011 again; jump to 0000 and clear on the edge that flags it.
        g = 4'b0000;
        repeat (2) @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        tests_run++; if (step_err !== 1'b1) begin fails++; $display("FAIL clr_with_err_step: got %b want 1", step_err); end
        tests_run++; if (err_cnt !== 8'd1) begin fails++; $display("FAIL clr_with_err_cnt: got %0d want 1", err_cnt); end
        clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        tests_run++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL clr_alone_cnt: got %0d want 0", err_cnt); end
        tests_run++; if (step_err !== 1'b0) begin fails++; $display("FAIL clr_alone_step: got %b want 0", step_err); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_up_walk();
        test_mid_reset();
        test_wrap();
        test_illegal_jump();
        test_saturation_clear();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
